// File: rtl/mix_serializer_pkg.sv
// rtl/mix_serializer_pkg.sv - shared types, constants and frame helper for mix_serializer
// Contents: state_t (IDLE/LOAD/SHIFT/GAP), frame/DAC/voice widths,
//           saturation limits, dac_frame() sample-to-frame conversion.
package mix_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int DAC_BITS   = 12;
   localparam int NUM_VOICES = 4;

   localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [15:0] SAT_MIN = 16'sh8000;

   // Flipping the sign bit turns two's complement into offset binary; the
   // logical shift keeps the top 12 bits and leaves the 4 control bits zero.
   function automatic logic [FRAME_BITS-1:0] dac_frame(input logic signed [15:0] s);
      return (s ^ SAT_MIN) >> (FRAME_BITS - DAC_BITS);
   endfunction

endpackage

// File: rtl/mix_serializer_sat_mix4.sv
// rtl/mix_serializer_sat_mix4.sv - combinational masked 4-voice saturating adder
// Ports: voice0..voice3 signed 16-bit samples, mask selects contributing
//        voices, mix is the 16-bit signed saturated sum.
module sat_mix4
   import mix_serializer_pkg::*;
(
   input  logic signed [15:0] voice0,
   input  logic signed [15:0] voice1,
   input  logic signed [15:0] voice2,
   input  logic signed [15:0] voice3,
   input  logic        [3:0]  mask,
   output logic signed [15:0] mix
);

   localparam logic signed [17:0] SUM_HI = 18'(SAT_MAX);
   localparam logic signed [17:0] SUM_LO = 18'(SAT_MIN);

   // 18 bits hold the sum of four 16-bit values without overflow.
   logic signed [17:0] sum;

   always_comb begin
      sum = '0;
      if (mask[0]) sum = sum + 18'(voice0);
      if (mask[1]) sum = sum + 18'(voice1);
      if (mask[2]) sum = sum + 18'(voice2);
      if (mask[3]) sum = sum + 18'(voice3);
      if (sum > SUM_HI)
         mix = SAT_MAX;
      else if (sum < SUM_LO)
         mix = SAT_MIN;
      else
         mix = sum[15:0];
   end

endmodule

// File: rtl/mix_serializer.sv
// rtl/mix_serializer.sv - voice mixer feeding a 16-bit serial DAC frame
// Ports: clk, reset (sync, active high), voice0..voice3 signed samples,
//        active voice mask, sample_strobe request; sclk/sync_n/sdata DAC
//        serial lines, busy (not idle), overrun (dropped strobe pulse).
module mix_serializer
   import mix_serializer_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] voice0,
   input  logic signed [15:0] voice1,
   input  logic signed [15:0] voice2,
   input  logic signed [15:0] voice3,
   input  logic        [3:0]  active,
   input  logic               sample_strobe,
   output logic               sclk,
   output logic               sync_n,
   output logic               sdata,
   output logic               busy,
   output logic               overrun
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t             state;
   logic               strobe_q;
   logic signed [15:0] v0_q, v1_q, v2_q, v3_q;
   logic        [3:0]  mask_q;
   logic signed [15:0] mix;
   logic [FRAME_BITS-1:0] frame;
   logic [FRAME_BITS-1:0] shift_q;
   logic        [3:0]  bit_cnt;
   logic        [7:0]  div_cnt;

   sat_mix4 u_sat_mix4 (
      .voice0 (v0_q),
      .voice1 (v1_q),
      .voice2 (v2_q),
      .voice3 (v3_q),
      .mask   (mask_q),
      .mix    (mix)
   );

   assign frame = dac_frame(mix);
   assign busy  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         strobe_q <= 1'b0;
         v0_q     <= '0;
         v1_q     <= '0;
         v2_q     <= '0;
         v3_q     <= '0;
         mask_q   <= '0;
         shift_q  <= '0;
         bit_cnt  <= '0;
         div_cnt  <= '0;
         sclk     <= 1'b1;
         sync_n   <= 1'b1;
         sdata    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         // A captured-but-not-yet-started request also makes a new strobe a drop.
         overrun  <= sample_strobe && ((state != IDLE) || strobe_q);
         strobe_q <= 1'b0;
         case (state)
            IDLE: begin
               // Inputs are captured at the strobe edge; LOAD follows one
               // edge later so the frame appears two edges after the strobe.
               if (sample_strobe && !strobe_q) begin
                  strobe_q <= 1'b1;
                  v0_q     <= voice0;
                  v1_q     <= voice1;
                  v2_q     <= voice2;
                  v3_q     <= voice3;
                  mask_q   <= active;
               end
               if (strobe_q)
                  state <= LOAD;
            end
            LOAD: begin
               state   <= SHIFT;
               sdata   <= frame[FRAME_BITS-1];
               shift_q <= {frame[FRAME_BITS-2:0], 1'b0};
               sync_n  <= 1'b0;
               sclk    <= 1'b1;
               bit_cnt <= '0;
               div_cnt <= '0;
            end
            SHIFT: begin
               // div_cnt times one half-period; sclk itself is the phase bit.
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (sclk) begin
                     sclk <= 1'b0;
                  end else if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                     state   <= GAP;
                     sclk    <= 1'b1;
                     sync_n  <= 1'b1;
                     sdata   <= 1'b0;
                     bit_cnt <= '0;
                  end else begin
                     sclk    <= 1'b1;
                     bit_cnt <= bit_cnt + 4'd1;
                     sdata   <= shift_q[FRAME_BITS-1];
                     shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            GAP: begin
               // Gap is two half-periods; bit_cnt counts them.
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt == 4'd1) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= 4'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_serializer.sv
// tb/tb_mix_serializer.sv - randomized self-checking bench for mix_serializer
module tb_mix_serializer;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] voice0, voice1, voice2, voice3;
   logic        [3:0]  active;
   logic               sample_strobe;
   logic               sclk, sync_n, sdata, busy, overrun;

   int n_vec = 0;
   int n_err = 0;

   mix_serializer #(.CLK_DIV(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .voice0        (voice0),
      .voice1        (voice1),
      .voice2        (voice2),
      .voice3        (voice3),
      .active        (active),
      .sample_strobe (sample_strobe),
      .sclk          (sclk),
      .sync_n        (sync_n),
      .sdata         (sdata),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: integer sum of enabled voices, clamp to 16-bit signed range,
   // keep the top 12 bits as offset binary (add half scale).
   function automatic logic [15:0] model_frame(input int a, input int b, input int c,
                                               input int d, input logic [3:0] act);
      int s;
      s = 0;
      if (act[0]) s += a;
      if (act[1]) s += b;
      if (act[2]) s += c;
      if (act[3]) s += d;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return 16'((s >>> 4) + 2048);
   endfunction

   function automatic logic signed [15:0] rand_voice();
      case ($urandom_range(0, 5))
         0:       return 16'sh7FFF;
         1:       return 16'sh8000;
         default: return 16'($urandom);
      endcase
   endfunction

   // Issue one strobe, check latency, collect the frame on sclk falling edges,
   // and measure sync_n low time and gap length. ovr_at>0 injects a second
   // strobe that many sync_n-low cycles into the frame.
   task automatic run_frame(input logic signed [15:0] a, input logic signed [15:0] b,
                            input logic signed [15:0] c, input logic signed [15:0] d,
                            input logic [3:0] act, input int ovr_at);
      logic [15:0] exp;
      logic [15:0] got;
      int          low_cnt;
      int          gap_cnt;
      int          ovr_stage;
      logic        prev_sclk;
      exp = model_frame(int'(a), int'(b), int'(c), int'(d), act);
      @(negedge clk);
      voice0 = a; voice1 = b; voice2 = c; voice3 = d; active = act;
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
      // Inputs were captured at the strobe edge; later changes must not matter.
      voice0 = 16'($urandom); voice1 = 16'($urandom);
      voice2 = 16'($urandom); voice3 = 16'($urandom); active = 4'($urandom);
      check_eq("busy_after_strobe_edge_idle", {31'd0, sync_n}, 32'd1);
      @(negedge clk);
      check_eq("sync_n_high_at_k1", {31'd0, sync_n}, 32'd1);
      @(negedge clk);
      check_eq("sync_n_low_at_k2", {31'd0, sync_n}, 32'd0);
      check_eq("first_bit", {31'd0, sdata}, {31'd0, exp[15]});
      low_cnt   = 1;
      got       = '0;
      prev_sclk = sclk;
      ovr_stage = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ovr_stage == 1) begin
            sample_strobe = 1'b0;
            check_eq("overrun_pulse", {31'd0, overrun}, 32'd1);
            ovr_stage = 2;
         end else if (ovr_stage == 2) begin
            check_eq("overrun_one_cycle", {31'd0, overrun}, 32'd0);
            ovr_stage = 3;
         end
         if (sync_n) break;
         low_cnt++;
         if (prev_sclk && !sclk) got = {got[14:0], sdata};
         prev_sclk = sclk;
         if (ovr_at > 0 && low_cnt == ovr_at) begin
            sample_strobe = 1'b1;
            ovr_stage = 1;
         end
      end
      check_eq("frame", 32'(got), 32'(exp));
      check_eq("sync_low_cycles", low_cnt, 64);
      check_eq("gap_lines", {29'd0, sclk, sdata, busy}, 32'b101);
      gap_cnt = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) break;
         gap_cnt++;
      end
      check_eq("gap_cycles", gap_cnt, 4);
   endtask

   int low_seen;

   initial begin
      reset = 1'b1;
      sample_strobe = 1'b0;
      voice0 = '0; voice1 = '0; voice2 = '0; voice3 = '0; active = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_lines", {27'd0, sclk, sync_n, sdata, busy, overrun}, 32'b11000);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_frame(16'sh1000, 16'sh1000, 16'sh1000, 16'sh1000, 4'hF, 0);
      run_frame(16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 4'hF, 0);
      run_frame(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 4'hF, 0);
      run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'h0, 0);

      for (int n = 0; n < 10; n++)
         run_frame(rand_voice(), rand_voice(), rand_voice(), rand_voice(), 4'($urandom), 0);

      // Second strobe mid-frame is dropped and no second frame follows.
      run_frame(16'sh1234, -16'sh0567, 16'sh0ABC, 16'sh7000, 4'b1011, 10);
      low_seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (!sync_n) low_seen++;
      end
      check_eq("no_second_frame", low_seen, 0);

      // Reset in the middle of a frame aborts it for good.
      @(negedge clk);
      voice0 = 16'sh2000; voice1 = 16'sh0100; voice2 = 16'sh0; voice3 = 16'sh0; active = 4'hF;
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
      repeat (2 + 7 * 4) @(negedge clk);
      check_eq("mid_frame_sync_low", {31'd0, sync_n}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_lines", {28'd0, sclk, sync_n, sdata, busy}, 32'b1100);
      reset = 1'b0;
      low_seen = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (!sync_n || busy) low_seen++;
      end
      check_eq("no_resume_after_reset", low_seen, 0);
      run_frame(-16'sh0100, 16'sh0040, 16'sh3000, -16'sh7000, 4'b0111, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mix_serializer.md
MIX_SERIALIZER -- requirements
Module: mix_serializer

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 voice0..voice3  input  16 each  signed per-voice sample (result of one synthesis voice).
REQ-005 active  input  4  bit n set means voice n contributes to the mix (the voice's activeout).
REQ-006 sample_strobe  input  1  one-cycle request to mix and transmit one sample.
REQ-007 sclk  output  1  DAC serial clock; idles high.
REQ-008 sync_n  output  1  DAC frame select; active low.
REQ-009 sdata  output  1  DAC serial data, MSB first.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 overrun  output  1  one-cycle pulse when a strobe is dropped.

Function
REQ-012 The state machine SHALL have states IDLE, LOAD, SHIFT and GAP.
REQ-013 IDLE: sample_strobe high at an edge SHALL move the state to LOAD and register the inputs.
- Registered: voice0..3 gated by active; inactive voice contributes 0.
REQ-014 LOAD SHALL compute an 18-bit signed sum of the gated voices, saturated to 16-bit signed.
- Clamp range: 16'sh7FFF / 16'sh8000.
REQ-015 DAC code SHALL be sat_sum[15:4] with bit 11 inverted (12-bit offset binary); frame = {4'b0000, code}.
REQ-016 LOAD SHALL last exactly one cycle, then go to SHIFT.
REQ-017 SHIFT SHALL hold sync_n low for exactly 16*2*CLK_DIV cycles.
- Each bit period: sdata valid for the whole period; sclk high for the first CLK_DIV cycles, low for the next CLK_DIV.
- DAC samples on the sclk falling edge.
REQ-018 After bit 0, SHIFT SHALL go to GAP.
- GAP: sync_n high, sclk high, sdata low, for 2*CLK_DIV cycles; then IDLE.
REQ-019 Strobe-to-output latency: strobe sampled at edge k; LOAD occupies cycle k+1; sync_n goes low and sdata shows frame bit 15 from edge k+2.
REQ-020 A strobe sampled in LOAD, SHIFT or GAP SHALL be ignored, and overrun SHALL pulse high for one cycle.
- A frame in progress SHALL NOT be disturbed by such a strobe.
REQ-021 A strobe on the cycle GAP ends (state not yet IDLE) SHALL count as an overrun.
REQ-022 sclk, sync_n and sdata SHALL be driven from registers, with no combinational path from inputs.
REQ-023 Bit counter (4 bits) and divider counter (8 bits) SHALL reset to 0 at entry to SHIFT.
- Neither counter wraps beyond its defined range.

Reset
REQ-024 reset SHALL force, on the next edge: state IDLE, sclk=1, sync_n=1, sdata=0, busy=0, overrun=0, all counters and the shift register 0.
REQ-025 Reset during any state, including mid-SHIFT, SHALL abort the frame; the partial frame is never completed or retransmitted.
REQ-026 reset SHALL take priority over a simultaneous sample_strobe.

Structure
REQ-027 The shared package SHALL hold these items:
- state enum (IDLE, LOAD, SHIFT, GAP);
- constants: FRAME_BITS=16, DAC_BITS=12, NUM_VOICES=4;
- the saturation limits.
REQ-028 The saturating adder SHALL be one sub-module, sat_mix4: four 16-bit signed inputs plus a 4-bit mask, 16-bit signed output, combinational.
- The FSM, divider and shifter stay in mix_serializer.

Verification
REQ-029 Unity mix: active=4'hF, all voices 16'sh1000, strobe → frame 16'h0C00 shifted MSB first.
- With CLK_DIV=2: sync_n low exactly 64 cycles, then 4 GAP cycles.
REQ-030 Positive saturation: all voices 16'sh7FFF, active=4'hF → frame 16'h0FFF.
REQ-031 Negative saturation and silence:
- All voices 16'sh8000, active=4'hF → frame 16'h0000.
- active=4'h0 with any voice values → frame 16'h0800.
REQ-032 Overrun: second strobe 10 cycles into SHIFT → overrun high one cycle, first frame bit-exact, no second frame.
REQ-033 Reset mid-frame: assert reset at SHIFT bit 7 → next edge sclk=1, sync_n=1, busy=0.
- A strobe two cycles after reset release → full new frame, sync_n low at strobe edge +2.
